// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with frame-synchronous double buffering,
// leading-zero blanking and PWM brightness.
module seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIV_WIDTH      = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic [DIV_WIDTH-1:0]    div_value,
    input  logic [2:0]              duty,
    input  logic                    blank_lz,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [DIV_WIDTH-1:0]    pre_cnt;
    logic [IDX_W-1:0]        idx;
    logic [2:0]              pwm_cnt;
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic                    pending;

    logic                  tick;
    logic                  wrap;
    logic                  accept;
    logic                  lit;
    logic                  run;
    logic [NUM_DIGITS-1:0] lz;
    logic [3:0]            nib;
    logic                  dp_bit;
    logic                  blank;
    logic [6:0]            pat;
    logic [7:0]            seg_raw;
    logic [NUM_DIGITS-1:0] an_raw;

    // >= (not ==) so a shrinking div_value never wraps through 2^DIV_WIDTH
    assign tick       = pre_cnt >= div_value;
    assign wrap       = tick && (idx == LAST);
    assign accept     = load_valid && !pending;
    assign load_ready = !pending;
    assign lit        = pwm_cnt <= duty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt    <= '0;
            idx        <= '0;
            pwm_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            pre_cnt    <= tick ? '0 : pre_cnt + DIV_WIDTH'(1);
            pwm_cnt    <= pwm_cnt + 3'd1;
            frame_done <= wrap;
            if (tick) begin
                idx <= wrap ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Shadow only moves to the display on a frame wrap, so frames never mix
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            disp_data   <= '0;
            disp_dp     <= '0;
            pending     <= 1'b0;
        end else if (wrap && pending) begin
            disp_data <= shadow_data;
            disp_dp   <= shadow_dp;
            pending   <= 1'b0;
        end else if (accept) begin
            shadow_data <= load_data;
            shadow_dp   <= load_dp;
            pending     <= 1'b1;
        end
    end

    // lz[i]: digit i and every higher digit are zero
    always_comb begin
        lz  = '0;
        run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run   = run && (disp_data[4*i +: 4] == 4'h0);
            lz[i] = run;
        end
        lz[0] = 1'b0;
    end

    always_comb begin
        nib    = '0;
        dp_bit = 1'b0;
        blank  = 1'b0;
        an_raw = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib       = disp_data[4*i +: 4];
                dp_bit    = disp_dp[i];
                blank     = lz[i];
                an_raw[i] = lit;
            end
        end
    end

    always_comb begin
        pat = 7'h00;
        unique case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            4'hF: pat = 7'h71;
        endcase
    end

    always_comb begin
        seg_raw = 8'h00;
        if (lit) begin
            seg_raw = {dp_bit, (blank_lz && blank) ? 7'h00 : pat};
        end
    end

    // XOR with the off pattern applies polarity at the output register only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_raw ^ SEG_OFF;
            an  <= an_raw ^ AN_OFF;
        end
    end

endmodule
